dtree_feature_sequencer: RTL and testbench

DTREE_FEATURE_SEQUENCER -- requirements
Module: dtree_feature_sequencer

---
 rtl/dtree_feature_sequencer.sv | 151 +++++++++++++++
 tb/tb_dtree_feature_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dtree_feature_sequencer.sv
// dtree_feature_sequencer
//   Collects a frame of NUM_FEAT feature bytes from a valid/ready byte stream
//   into a parallel vector for a combinational decision-tree classifier,
//   holds that vector for EVAL_CYCLES cycles, captures the returned class and
//   presents it on a valid/ready result port.
//   Frames whose in_last does not line up with the final slot set a sticky
//   error flag and produce no result. Over-long frames have their remaining
//   bytes swallowed until in_last.
//
// Ports
//   clk, rst_n             clock (rising edge) / asynchronous active-low reset
//   in_valid/in_ready      byte stream handshake
//   in_data, in_last       feature byte and end-of-frame marker
//   feat_vec               slot k at [k*FEAT_W +: FEAT_W]
//   class_in               class from the classifier (combinational)
//   out_valid/out_ready    result handshake
//   out_class              captured class
//   err_sticky             frame-error flag, cleared only by reset
//   sample_cnt             completed results, 16-bit wrapping
module dtree_feature_sequencer #(
  parameter int NUM_FEAT    = 5,
  parameter int FEAT_W      = 8,
  parameter int CLASS_W     = 2,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FEAT_W-1:0]          in_data,
  input  logic                       in_last,
  output logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]         class_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       err_sticky,
  output logic [15:0]                sample_cnt
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_FEAT - 1);
  localparam logic [3:0] EVAL_INIT = 4'(EVAL_CYCLES);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic [3:0]         r_eval_cnt;
  logic               r_in_ready;
  logic               r_err;
  logic [CLASS_W-1:0] r_out_class;
  logic [15:0]        r_sample_cnt;

  logic w_xfer;
  logic w_load_xfer;
  logic w_idx_at_max;
  logic w_out_fire;
  logic w_eval_done;

  assign w_xfer       = in_valid & r_in_ready;
  assign w_load_xfer  = w_xfer & (r_state == S_LOAD);
  assign w_idx_at_max = (r_idx == IDX_MAX);
  assign w_out_fire   = (r_state == S_OUT) & out_ready;
  assign w_eval_done  = (r_state == S_EVAL) & (r_eval_cnt == 4'd1);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_LOAD: begin
        if (w_xfer) begin
          if (w_idx_at_max) begin
            w_idx_next   = '0;
            // Last slot filled: a proper frame ends here, otherwise it is too long.
            w_state_next = in_last ? S_EVAL : S_DRAIN;
          end else if (in_last) begin
            w_idx_next = '0;  // short frame: discard and restart
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      S_EVAL:  if (r_eval_cnt == 4'd1) w_state_next = S_OUT;
      S_OUT:   if (out_ready) w_state_next = S_LOAD;
      S_DRAIN: if (w_xfer && in_last) w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOAD;
      r_idx        <= '0;
      r_eval_cnt   <= '0;
      r_in_ready   <= 1'b0;
      r_err        <= 1'b0;
      r_out_class  <= '0;
      r_sample_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      // Ready is registered from the next state so it rises one edge after
      // reset release and never depends combinationally on out_ready.
      r_in_ready <= (w_state_next == S_LOAD) || (w_state_next == S_DRAIN);
      if (w_load_xfer && w_idx_at_max && in_last) begin
        r_eval_cnt <= EVAL_INIT;
      end else if (r_state == S_EVAL) begin
        r_eval_cnt <= r_eval_cnt - 4'd1;
      end
      if (w_eval_done) begin
        r_out_class <= class_in;
      end
      // Error when in_last and the final slot disagree (short or long frame).
      if (w_load_xfer && (w_idx_at_max != in_last)) begin
        r_err <= 1'b1;
      end
      if (w_out_fire) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
    end
  end

  // One register per feature slot; slots only change while loading, so the
  // vector is frozen during EVAL and OUT.
  generate
    for (genvar gi = 0; gi < NUM_FEAT; gi++) begin : g_slot
      logic [FEAT_W-1:0] r_slot;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slot <= '0;
        end else if (w_load_xfer && (r_idx == IDX_W'(gi))) begin
          r_slot <= in_data;
        end
      end
      assign feat_vec[gi*FEAT_W +: FEAT_W] = r_slot;
    end
  endgenerate

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state == S_OUT);
  assign out_class  = r_out_class;
  assign err_sticky = r_err;
  assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Testbench for dtree_feature_sequencer: directed frames followed by random
// frames, checked against a frame-level reference model.
module tb_dtree_feature_sequencer;
  localparam int NUM_FEAT    = 5;
  localparam int FEAT_W      = 8;
  localparam int CLASS_W     = 2;
  localparam int EVAL_CYCLES = 1;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [FEAT_W-1:0]          in_data = '0;
  logic                       in_last = 1'b0;
  logic [NUM_FEAT*FEAT_W-1:0] feat_vec;
  logic [CLASS_W-1:0]         class_in = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [CLASS_W-1:0]         out_class;
  logic                       err_sticky;
  logic [15:0]                sample_cnt;

  always #5 clk = ~clk;

  dtree_feature_sequencer #(
    .NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .EVAL_CYCLES(EVAL_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .feat_vec(feat_vec), .class_in(class_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .err_sticky(err_sticky), .sample_cnt(sample_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, updated per frame.
  logic [NUM_FEAT*FEAT_W-1:0] m_feat = '0;
  logic                       m_err  = 1'b0;
  logic [15:0]                m_cnt  = '0;
  logic [FEAT_W-1:0]          fb [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [FEAT_W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [CLASS_W-1:0] cls, input int hold);
    class_in = cls;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send_byte(fb[i], (i == len - 1));
      if (i < NUM_FEAT) m_feat[i*FEAT_W +: FEAT_W] = fb[i];
    end
    if (len == NUM_FEAT) begin
      for (int c = 0; c < EVAL_CYCLES; c++) begin
        chk("eval_out_valid", 64'(out_valid), 64'd0);
        chk("eval_in_ready", 64'(in_ready), 64'd0);
        tick();
      end
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_class", 64'(out_class), 64'(cls));
      chk("feat_vec", 64'(feat_vec), 64'(m_feat));
      class_in = ~cls;
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_class", 64'(out_class), 64'(cls));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_cnt", 64'(sample_cnt), 64'(m_cnt));
        chk("hold_feat", 64'(feat_vec), 64'(m_feat));
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      m_cnt = m_cnt + 16'd1;
      chk("done_valid", 64'(out_valid), 64'd0);
      chk("done_cnt", 64'(sample_cnt), 64'(m_cnt));
      chk("done_in_ready", 64'(in_ready), 64'd1);
    end else begin
      m_err = 1'b1;
      for (int c = 0; c < 2; c++) begin
        chk("bad_out_valid", 64'(out_valid), 64'd0);
        chk("bad_in_ready", 64'(in_ready), 64'd1);
        tick();
      end
      chk("bad_feat", 64'(feat_vec), 64'(m_feat));
      chk("bad_cnt", 64'(sample_cnt), 64'(m_cnt));
    end
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 8; i++) fb[i] = FEAT_W'($urandom);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_feat", 64'(feat_vec), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Nominal frame.
    fb[0] = 8'h10; fb[1] = 8'h20; fb[2] = 8'h30; fb[3] = 8'h40; fb[4] = 8'h50;
    run_frame(5, 2'd2, 0);
    chk("nominal_vec", 64'(feat_vec), 64'h50_4030_2010);

    // Short frame, then a good one.
    rand_bytes();
    run_frame(3, 2'd1, 0);
    rand_bytes();
    run_frame(5, 2'd3, 1);

    // Long frame drained through to in_last.
    rand_bytes();
    run_frame(7, 2'd0, 0);

    // Backpressure for 10 cycles.
    rand_bytes();
    run_frame(5, 2'd1, 10);

    // Reset in the middle of a frame.
    rand_bytes();
    send_byte(fb[0], 1'b0);
    send_byte(fb[1], 1'b0);
    #3 rst_n = 1'b0;
    #1;
    m_feat = '0; m_err = 1'b0; m_cnt = '0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_class", 64'(out_class), 64'd0);
    chk("mid_rst_feat", 64'(feat_vec), 64'd0);
    chk("mid_rst_err", 64'(err_sticky), 64'd0);
    chk("mid_rst_cnt", 64'(sample_cnt), 64'd0);
    tick();
    chk("rst_held_in_ready", 64'(in_ready), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("rerst_in_ready", 64'(in_ready), 64'd1);
    rand_bytes();
    run_frame(5, 2'd3, 2);

    // Random frames: mostly well-formed, some short or long.
    for (int f = 0; f < 60; f++) begin
      int len;
      rand_bytes();
      len = ($urandom_range(0, 1) == 0) ? NUM_FEAT : int'($urandom_range(1, 8));
      run_frame(len, CLASS_W'($urandom), int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
